// File: rtl/sfq_toggle_capture.sv
// Decodes toggle-encoded RSFQ gate clock/output lines into one bit per gate clock
// window, packs the bits into words and hands them out over valid/ready.
module sfq_toggle_capture #(
    parameter int WORD_W  = 8,
    parameter int WIN_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sfq_clk_in,
    input  logic              sfq_q_in,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow,
    output logic              multi_err,
    output logic [CNT_W-1:0]  stray_cnt
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WC_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state;
    logic [WC_W-1:0]   cnt;
    logic              hit;
    logic              s_clk, s_q, p_clk, p_q, primed;
    logic              clk_pulse, q_pulse;
    logic              shift_en, shift_bit, word_done, xfer;
    logic              stray_hit, multi_hit;
    logic [WORD_W-1:0] acc, new_word;
    logic [IDX_W-1:0]  bit_idx;

    // Input sampling; primed masks the first compare after reset so a high
    // level at reset exit never reads as a pulse.
    always_ff @(posedge clk) begin
        s_clk <= sfq_clk_in;
        s_q   <= sfq_q_in;
        p_clk <= s_clk;
        p_q   <= s_q;
        if (rst) primed <= 1'b0;
        else     primed <= 1'b1;
    end

    assign clk_pulse = primed & (s_clk ^ p_clk);
    assign q_pulse   = primed & (s_q ^ p_q);

    // Window decode. The detection cycle counts as the first window cycle, so
    // a window opened from IDLE/CLOSE spends WIN_CYC-1 cycles in OPEN, while an
    // early close reopens one cycle later and spends all WIN_CYC cycles there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hit   <= 1'b0;
        end else begin
            case (state)
                OPEN: begin
                    if (clk_pulse) begin
                        cnt <= WC_W'(WIN_CYC - 1);
                        hit <= 1'b0;
                    end else begin
                        if (q_pulse) hit <= 1'b1;
                        if (cnt == '0) state <= CLOSE;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                default: begin
                    if (clk_pulse) begin
                        hit <= q_pulse;
                        cnt <= (WIN_CYC > 1) ? WC_W'(WIN_CYC - 2) : '0;
                        state <= (WIN_CYC > 1) ? OPEN : CLOSE;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        multi_hit = 1'b0;
        stray_hit = 1'b0;
        case (state)
            OPEN: begin
                multi_hit = q_pulse & hit;
                if (clk_pulse) begin
                    shift_en  = 1'b1;
                    shift_bit = hit | q_pulse;
                end
            end
            CLOSE: begin
                shift_en  = 1'b1;
                shift_bit = hit;
                stray_hit = q_pulse & ~clk_pulse;
            end
            default: stray_hit = q_pulse & ~clk_pulse;
        endcase
    end

    assign word_done = shift_en && (bit_idx == IDX_W'(WORD_W - 1));
    assign new_word  = acc | (WORD_W'(shift_bit) << bit_idx);
    assign xfer      = word_valid & word_ready;

    // Packing and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            bit_idx    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            multi_err  <= 1'b0;
            stray_cnt  <= '0;
        end else begin
            if (shift_en) begin
                if (word_done) begin
                    acc     <= '0;
                    bit_idx <= '0;
                end else begin
                    acc     <= new_word;
                    bit_idx <= bit_idx + 1'b1;
                end
            end
            if (word_done) begin
                if (!word_valid || xfer) begin
                    word_data  <= new_word;
                    word_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (xfer) begin
                word_valid <= 1'b0;
            end
            if (multi_hit) multi_err <= 1'b1;
            if (stray_hit) stray_cnt <= sat_inc(stray_cnt);
        end
    end

endmodule

// File: tb/tb_sfq_toggle_capture.sv
// Scoreboard bench for sfq_toggle_capture: a window-level reference model turns
// each stimulus table into expected transfers and final flag values.
module tb_sfq_toggle_capture;
    localparam int WIN  = 4;
    localparam int MAXL = 4200;

    logic       clk = 1'b0, rst = 1'b1;
    logic       sfq_clk_in = 1'b0, sfq_q_in = 1'b0, word_ready = 1'b0;
    logic [7:0] word_data, stray_cnt;
    logic       word_valid, overflow, multi_err;

    sfq_toggle_capture #(.WORD_W(8), .WIN_CYC(WIN), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sfq_clk_in(sfq_clk_in), .sfq_q_in(sfq_q_in),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .overflow(overflow), .multi_err(multi_err), .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] w; int t;} exp_t;
    exp_t exp_q[$];

    bit         clk_tog[MAXL], q_tog[MAXL], rdy[MAXL];
    bit         cov[MAXL+16], comp[MAXL+16];
    logic [7:0] comp_w[MAXL+16];
    int         L;
    int         n_chk = 0, n_err = 0;
    int         cur_t = -1;
    int         nb, m_stray;
    logic [7:0] acc_m, m_hw;
    bit         m_multi, m_ovf, m_held;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic clear_stim(int len);
        L = len;
        for (int i = 0; i < MAXL; i++) begin
            clk_tog[i] = 0; q_tog[i] = 0; rdy[i] = 0;
        end
    endtask

    // One gate clock pulse at drive cycle b, with an output pulse 2 cycles later if v.
    task automatic add_win(int b, bit v);
        clk_tog[b] = 1;
        if (v) q_tog[b+2] = 1;
    endtask

    task automatic add_word(int b0, logic [7:0] pat);
        for (int k = 0; k < 8; k++) add_win(b0 + 10*k, pat[k]);
    endtask

    // Window covering detection cycles [a,b]; its bit is taken at cycle sc.
    task automatic close_win(int a, int b, int sc);
        int n = 0;
        for (int c = a; c <= b; c++) begin
            cov[c] = 1;
            if (c >= 1 && c - 1 < L && q_tog[c-1]) n++;
        end
        if (n > 1) m_multi = 1;
        acc_m[nb] = (n > 0);
        nb++;
        if (nb == 8) begin
            comp[sc] = 1; comp_w[sc] = acc_m; nb = 0; acc_m = '0;
        end
    endtask

    // A line change driven in cycle t is detected in cycle t+1.
    task automatic build_model();
        int ws = 0, wc = 0;
        bit open = 0;
        bit xf;
        for (int i = 0; i < MAXL + 16; i++) begin cov[i] = 0; comp[i] = 0; comp_w[i] = '0; end
        nb = 0; acc_m = '0; m_multi = 0; m_ovf = 0; m_held = 0; m_stray = 0; m_hw = '0;
        exp_q.delete();
        for (int d = 1; d <= L; d++) begin
            if (clk_tog[d-1]) begin
                if (open && d < wc) begin
                    close_win(ws, d, d);
                    ws = d + 1; wc = d + 1 + WIN;
                end else begin
                    if (open) close_win(ws, wc - 1, wc);
                    ws = d; wc = d + WIN;
                end
                open = 1;
            end
        end
        if (open) close_win(ws, wc - 1, wc);
        for (int c = 1; c <= L; c++)
            if (q_tog[c-1] && !cov[c] && m_stray < 255) m_stray++;
        for (int e = 0; e < L; e++) begin
            xf = m_held && rdy[e];
            if (xf) exp_q.push_back('{w: m_hw, t: e});
            if (comp[e]) begin
                if (!m_held || xf) begin m_held = 1; m_hw = comp_w[e]; end
                else m_ovf = 1;
            end else if (xf) begin
                m_held = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer_t", 32'(cur_t), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_data", 32'(word_data), 32'(e.w));
                chk("xfer_cycle", 32'(cur_t), 32'(e.t));
            end
        end
    end

    task automatic run_phase(string nm, bit raise_lines);
        build_model();
        @(posedge clk); #1;
        rst = 1; word_ready = 0; cur_t = -1;
        repeat (2) begin @(posedge clk); #1; end
        if (raise_lines) begin sfq_clk_in = 1; sfq_q_in = 1; end
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_rst_valid"}, 32'(word_valid), 0);
        chk({nm, "_rst_data"}, 32'(word_data), 0);
        chk({nm, "_rst_ovf"}, 32'(overflow), 0);
        chk({nm, "_rst_multi"}, 32'(multi_err), 0);
        chk({nm, "_rst_stray"}, 32'(stray_cnt), 0);
        for (int t = 0; t < L; t++) begin
            @(posedge clk); #1;
            rst = 0; cur_t = t;
            if (clk_tog[t]) sfq_clk_in = ~sfq_clk_in;
            if (q_tog[t]) sfq_q_in = ~sfq_q_in;
            word_ready = rdy[t];
        end
        @(posedge clk); #1;
        word_ready = 0; cur_t = L;
        @(negedge clk);
        chk({nm, "_overflow"}, 32'(overflow), 32'(m_ovf));
        chk({nm, "_multi_err"}, 32'(multi_err), 32'(m_multi));
        chk({nm, "_stray_cnt"}, 32'(stray_cnt), 32'(m_stray));
        chk({nm, "_valid_end"}, 32'(word_valid), 32'(m_held));
        if (m_held) chk({nm, "_held_data"}, 32'(word_data), 32'(m_hw));
        chk({nm, "_pending_xfers"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Decode 0xA5, held with ready low; lines rise during reset.
        clear_stim(100);
        add_word(2, 8'hA5);
        run_phase("decode", 1);

        // Output pulses 6 cycles after each clock pulse are strays; 300 saturate.
        clear_stim(3010);
        for (int k = 0; k < 300; k++) begin
            clk_tog[2 + 10*k] = 1;
            q_tog[8 + 10*k] = 1;
        end
        for (int t = 0; t < 3010; t++) rdy[t] = 1;
        run_phase("stray", 0);

        // Early close with an output pulse, then a window with two output pulses.
        clear_stim(120);
        clk_tog[2] = 1; q_tog[3] = 1; clk_tog[4] = 1; q_tog[6] = 1; q_tog[7] = 1;
        for (int k = 0; k < 6; k++) add_win(20 + 10*k, k[0]);
        for (int t = 0; t < 120; t++) rdy[t] = 1;
        run_phase("early", 0);

        // Backpressure: 0x3C held, 0xFF dropped, then 0x3C transfers.
        clear_stim(200);
        add_word(2, 8'h3C);
        add_word(82, 8'hFF);
        for (int t = 170; t < 200; t++) rdy[t] = 1;
        run_phase("backpressure", 0);

        // Ready rises exactly as the second word completes.
        clear_stim(200);
        add_word(2, 8'h5A);
        add_word(82, 8'h96);
        for (int t = 157; t < 200; t++) rdy[t] = 1;
        run_phase("same_cycle", 0);

        // Randomized traffic.
        for (int r = 0; r < 2; r++) begin
            int t;
            clear_stim(1500);
            t = 2;
            while (t < L - 20) begin
                clk_tog[t] = 1;
                t += $urandom_range(1, 12);
            end
            for (int i = 2; i < L - 20; i++) q_tog[i] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < L; i++) rdy[i] = ($urandom_range(0, 9) < 7);
            run_phase("random", 0);
        end

        // Five bits then stop inside an open window; the next phase resets there.
        clear_stim(55);
        for (int k = 0; k < 5; k++) add_win(2 + 10*k, 1);
        clk_tog[52] = 1;
        run_phase("partial", 0);

        clear_stim(120);
        add_word(2, 8'h81);
        for (int t = 0; t < 120; t++) rdy[t] = 1;
        run_phase("after_reset", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
